palette_lookup_arbiter: RTL and testbench
=========================================

# palette_lookup_arbiter

Shares one combinational 512-entry, 12-bit sprite palette ROM among up to NUM_REQ sprite-layer requesters (player, bubbles, harpoon, HUD) in the Bubble Trouble VGA pipeline. It grants one palette index per cycle with round-robin fairness and drives the shared ROM address. It returns the looked-up RGB, tagged with requester ID and a transparency flag, over a valid/ready response channel. Full throughput is one lookup per cycle; request-to-response latency is a fixed 2 cycles.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 9, palette index width
- TRANSP_IDX, 9'd0, index treated as transparent (color key)

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_index  in  NUM_REQ x IDX_W  per-requester palette index
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
- pal_index  out  IDX_W  address to shared palette ROM
- pal_red, pal_green, pal_blue  in  4 each  combinational ROM data for pal_index
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_id  out  $clog2(NUM_REQ)  requester that issued the lookup
- rsp_rgb  out  12  {red, green, blue}
- rsp_transparent  out  1  looked-up index == TRANSP_IDX

## Operation
- Two pipeline stages. S1 holds the granted index and ID, and drives pal_index. S2 captures the ROM output into rsp_*.
- advance = !rsp_valid | rsp_ready. Both stages move only when advance is high. When advance is low, everything holds and req_ready is all-zero.
- Grant happens only when advance is high. It goes to the first valid requester searching upward from (last_grant+1) mod NUM_REQ. At most one req_ready bit is set, and only if the matching req_valid is set.
- last_grant updates only on a completed handshake.
- On advance, S1 loads the grant, or becomes invalid if nothing was granted. S2 loads S1 (rsp_valid <= s1_valid).
- rsp_transparent is computed from the S1 index and registered alongside the RGB.
- pal_index holds its last value while S1 is empty, so the ROM stays quiet.
- Responses leave in grant order, with no reordering or drops.

## Timing
- Reset values: S1 invalid, rsp_valid=0, rsp_id=0, rsp_rgb=12'h000, rsp_transparent=0, pal_index=0, last_grant=NUM_REQ-1 (requester 0 wins first), req_ready=0.
- Handshake at edge N → pal_index valid during cycle N+1 → rsp_valid high in cycle N+2.
- Back-to-back grants every cycle while rsp_ready=1.
- rsp_ready low with rsp_valid high: rsp_* stable, S1 stable, req_ready=0, no grants, round-robin pointer frozen.
- rsp_ready high while rsp_valid is low: accepted, no effect beyond advancing.
- A single persistent requester is granted every cycle. Other requesters are never starved: the worst-case wait is NUM_REQ-1 grants.
- Reset mid-operation: in-flight S1/S2 contents are discarded, the pointer returns to NUM_REQ-1, and no response is emitted for dropped lookups.
- Index arithmetic is unsigned IDX_W. The pointer wraps modulo NUM_REQ, including for non-power-of-two NUM_REQ.

## Structure
- Package palette_pkg holds IDX_W, NUM_REQ defaults, TRANSP_IDX, typedef rgb12_t (3×4-bit struct), and typedef req_id_t.
- Sub-module rr_arbiter (NUM_REQ) contains the request vector, enable, and pointer update-on-accept, and produces the one-hot grant plus the encoded ID.
- The palette ROM stays external and is instantiated beside this block in the sprite top.

## Test plan
- Reset, then req_valid=4'b0001 with index 1 held → from cycle 2, rsp_valid=1, id=0, rgb=12'hFFF, transparent=0 every cycle.
- Requesters 0..3 all valid with indices 2, 3, 10, 0 → grants in order 0,1,2,3,0… Responses 12'h233, 12'h2AB, 12'h000, 12'hE55; id 3 has transparent=1.
- Same stimulus with rsp_ready low for 3 cycles mid-stream → rsp_* held, req_ready=0, and the sequence resumes with no loss or duplication.
- Only requesters 1 and 3 valid → alternating grants 1,3,1,3. Check that neither waits more than 1 grant.
- Reset asserted while S1 and S2 are both full → next cycle rsp_valid=0. The first post-reset grant goes to the lowest valid requester.
- Random valid/ready over 10k cycles against a reference model → exact RGB/ID match, in order, no starvation beyond NUM_REQ-1.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and defaults for the sprite palette lookup arbiter.
// Holds the RGB struct, the requester-ID type and the parameter defaults.
package palette_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_IDX_W = 9;
  localparam logic [DEF_IDX_W-1:0] DEF_TRANSP_IDX = 9'd0;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

  function automatic rgb12_t pack_rgb(input logic [3:0] r, input logic [3:0] g,
                                      input logic [3:0] b);
    pack_rgb = '{red: r, green: g, blue: b};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded ID, searching upward from last_grant+1.
// The pointer moves only when a grant is issued, and every grant is a completed handshake.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);
  logic [ID_W-1:0] last_grant;

  // Candidate index wraps by subtraction so non-power-of-two NUM_REQ works.
  always_comb begin
    int cand;
    gnt = '0;
    gnt_id = '0;
    gnt_any = 1'b0;
    cand = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en && !gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_id = ID_W'(cand);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= ID_W'(NUM_REQ - 1);
    else if (gnt_any) last_grant <= gnt_id;
  end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational sprite palette ROM among NUM_REQ requesters.
// Two-stage pipeline: S1 drives the ROM address, S2 holds the tagged RGB response.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(DEF_TRANSP_IDX),
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [IDX_W-1:0]              pal_index,
  input  logic [3:0]                    pal_red,
  input  logic [3:0]                    pal_green,
  input  logic [3:0]                    pal_blue,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [11:0]                   rsp_rgb,
  output logic                          rsp_transparent
);
  logic               advance;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;

  logic               vld_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [ID_W-1:0]    id_p1;
  rgb12_t             rgb_p2;

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = gnt;
  assign pal_index = idx_p1;
  assign rsp_rgb   = rgb_p2;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (Clk),
    .rst    (Reset),
    .req    (req_valid),
    .en     (advance),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .gnt_any(gnt_any)
  );

  // S1: granted index and ID; the index only reloads on a grant so the ROM address stays quiet
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      id_p1  <= '0;
    end else if (advance) begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        idx_p1 <= req_index[gnt_id];
        id_p1  <= gnt_id;
      end
    end
  end

  // S2: ROM data captured with ID and colour-key flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rgb_p2          <= '0;
      rsp_transparent <= 1'b0;
    end else if (advance) begin
      rsp_valid <= vld_p1;
      if (vld_p1) begin
        rsp_id          <= id_p1;
        rgb_p2          <= pack_rgb(pal_red, pal_green, pal_blue);
        rsp_transparent <= (idx_p1 == TRANSP_IDX);
      end
    end
  end
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_palette_lookup_arbiter;
  localparam int NUM_REQ = 4;

  logic                      Clk;
  logic                      Reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][8:0]   req_index;
  logic [NUM_REQ-1:0]        req_ready;
  logic [8:0]                pal_index;
  logic [3:0]                pal_red, pal_green, pal_blue;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [11:0]               rsp_rgb;
  logic                      rsp_transparent;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  typedef struct {
    int          id;
    logic [11:0] rgb;
    logic        tr;
  } rsp_t;
  rsp_t got[$];

  palette_lookup_arbiter dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .pal_index(pal_index), .pal_red(pal_red),
    .pal_green(pal_green), .pal_blue(pal_blue), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb),
    .rsp_transparent(rsp_transparent)
  );

  function automatic logic [11:0] rom(input logic [8:0] idx);
    case (idx)
      9'd0:    return 12'hE55;
      9'd1:    return 12'hFFF;
      9'd2:    return 12'h233;
      9'd3:    return 12'h2AB;
      9'd10:   return 12'h000;
      default: return {idx[3:0], idx[7:4], idx[8], idx[2:0]} ^ 12'h5A5;
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = rom(pal_index);

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // first valid requester at or after (ptr+1) mod NUM_REQ
  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (ptr + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // model state: what the DUT must show after the next rising edge
  int          m_ptr = NUM_REQ - 1;
  bit          m_s1v = 0;
  int          m_s1id = 0;
  logic [8:0]  m_s1idx = '0;
  logic [8:0]  m_pal = '0;
  bit          m_rv = 0;
  int          m_rid = 0;
  logic [11:0] m_rgb = '0;
  bit          m_tr = 0;
  int          waits[NUM_REQ] = '{default: 0};

  always @(negedge Clk) begin
    int g;
    bit adv;
    adv = !m_rv || rsp_ready;
    g = adv ? rr_pick(m_ptr, req_valid) : -1;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("pal_index", 32'(pal_index), 32'(m_pal));
      if (m_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("rsp_rgb", 32'(rsp_rgb), 32'(m_rgb));
        chk("rsp_transparent", 32'(rsp_transparent), 32'(m_tr));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (Reset || !req_valid[i] || req_ready[i]) waits[i] = 0;
        else if (req_ready != '0) begin
          waits[i]++;
          chk("starvation", 32'(waits[i] <= NUM_REQ - 1), 32'd1);
        end
      end
      if (rsp_valid && rsp_ready && !Reset)
        got.push_back('{id: int'(rsp_id), rgb: rsp_rgb, tr: rsp_transparent});
    end
    if (Reset) begin
      m_ptr = NUM_REQ - 1; m_s1v = 0; m_s1id = 0; m_s1idx = '0; m_pal = '0;
      m_rv = 0; m_rid = 0; m_rgb = '0; m_tr = 0;
    end else if (adv) begin
      m_rv = m_s1v;
      if (m_s1v) begin
        m_rid = m_s1id;
        m_rgb = rom(m_s1idx);
        m_tr  = (m_s1idx == 9'd0);
      end
      m_s1v = (g >= 0);
      if (g >= 0) begin
        m_s1id  = g;
        m_s1idx = req_index[g];
        m_pal   = req_index[g];
        m_ptr   = g;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; req_valid = '0; rsp_ready = 1;
    step(2);
    Reset = 0;
  endtask

  task automatic set_std_index();
    req_index[0] = 9'd2; req_index[1] = 9'd3; req_index[2] = 9'd10; req_index[3] = 9'd0;
  endtask

  logic [11:0] lit_rgb[NUM_REQ] = '{12'h233, 12'h2AB, 12'h000, 12'hE55};

  task automatic check_seq(input string nm, input int n, input int stride, input int first);
    chk({nm, "_count"}, 32'(got.size() >= n), 32'd1);
    for (int k = 0; k < n && k < got.size(); k++) begin
      int e;
      e = (first + k * stride) % NUM_REQ;
      chk({nm, "_id"}, 32'(got[k].id), 32'(e));
      chk({nm, "_rgb"}, 32'(got[k].rgb), 32'(lit_rgb[e]));
      chk({nm, "_tr"}, 32'(got[k].tr), 32'(e == 3));
    end
  endtask

  initial begin
    Reset = 1; req_valid = '0; req_index = '0; rsp_ready = 1;
    step(2);
    Reset = 0;
    chk_en = 1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);

    // single persistent requester 0, index 1
    req_valid = 4'b0001; req_index[0] = 9'd1;
    step(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("t1_valid", 32'(rsp_valid), 32'd1);
      chk("t1_id", 32'(rsp_id), 32'd0);
      chk("t1_rgb", 32'(rsp_rgb), 32'hFFF);
      chk("t1_tr", 32'(rsp_transparent), 32'd0);
      chk("t1_ready", 32'(req_ready), 32'b0001);
      step(1);
    end

    // all four requesters, full throughput
    do_reset();
    got.delete();
    set_std_index();
    req_valid = 4'b1111;
    step(10);
    req_valid = '0;
    step(4);
    check_seq("t2", 8, 1, 0);

    // mid-stream consumer stall
    do_reset();
    got.delete();
    req_valid = 4'b1111;
    step(5);
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_valid", 32'(rsp_valid), 32'd1);
      step(1);
    end
    rsp_ready = 1;
    step(10);
    req_valid = '0;
    step(4);
    check_seq("t3", 12, 1, 0);

    // only requesters 1 and 3 alternate
    do_reset();
    got.delete();
    req_valid = 4'b1010;
    step(8);
    req_valid = '0;
    step(4);
    check_seq("t4", 6, 2, 1);

    // reset with both stages full
    do_reset();
    req_valid = 4'b1111;
    step(4);
    Reset = 1;
    req_valid = 4'b0110;
    step(1);
    @(negedge Clk);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'b0010);
    step(1);
    Reset = 0;
    @(negedge Clk);
    chk("t5_first_grant", 32'(req_ready), 32'b0010);
    step(3);

    // random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) req_index[i] = 9'($urandom_range(0, 511));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
